// File: rtl/timer_avalon_master.sv
// Avalon-MM initiator for the 16-bit-halfword interval timer: programs the period,
// starts/stops it, services its IRQ into a tick pulse/count and reads 64-bit snapshots.
module timer_avalon_master #(
  parameter int unsigned TICK_W     = 32,
  parameter bit          CONTINUOUS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_stop,
  input  logic              cmd_snap,
  input  logic [63:0]       cfg_period,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              snap_valid,
  output logic [63:0]       snap_value,
  output logic [3:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              irq
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_P0    = 4'd1;
  localparam logic [3:0] S_WR_P1    = 4'd2;
  localparam logic [3:0] S_WR_P2    = 4'd3;
  localparam logic [3:0] S_WR_P3    = 4'd4;
  localparam logic [3:0] S_WR_CTRL  = 4'd5;
  localparam logic [3:0] S_RUN      = 4'd6;
  localparam logic [3:0] S_CLR_IRQ  = 4'd7;
  localparam logic [3:0] S_CLR_WAIT = 4'd8;
  localparam logic [3:0] S_STOP_WR  = 4'd9;
  localparam logic [3:0] S_SNAP_WR  = 4'd10;
  localparam logic [3:0] S_SNAP_RD0 = 4'd11;
  localparam logic [3:0] S_SNAP_RD1 = 4'd12;
  localparam logic [3:0] S_SNAP_RD2 = 4'd13;
  localparam logic [3:0] S_SNAP_RD3 = 4'd14;
  localparam logic [3:0] S_SNAP_RD4 = 4'd15;

  localparam logic [15:0] CTRL_WORD = CONTINUOUS ? 16'h0007 : 16'h0005;

  logic [3:0]        state_q, state_d;
  logic [63:0]       period_q, period_d;
  logic              running_q, running_d;
  logic              tick_q, tick_d;
  logic [TICK_W-1:0] tick_count_q, tick_count_d;
  logic              snap_valid_q, snap_valid_d;
  logic [63:0]       snap_value_q, snap_value_d;
  logic              cs_q, cs_d;
  logic              write_n_q, write_n_d;
  logic [3:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    running_d    = running_q;
    tick_d       = 1'b0;
    tick_count_d = tick_count_q;
    snap_valid_d = 1'b0;
    snap_value_d = snap_value_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d      = S_WR_P0;
          period_d     = cfg_period;
          tick_count_d = '0;
        end else if (cmd_stop) begin
          state_d = S_STOP_WR;
        end
      end
      S_RUN: begin
        if (cmd_start) begin
          state_d      = S_WR_P0;
          period_d     = cfg_period;
          tick_count_d = '0;
        end else if (cmd_stop) begin
          state_d = S_STOP_WR;
        end else if (irq) begin
          state_d = S_CLR_IRQ;
        end else if (cmd_snap) begin
          state_d = S_SNAP_WR;
        end
      end
      S_WR_P0:   state_d = S_WR_P1;
      S_WR_P1:   state_d = S_WR_P2;
      S_WR_P2:   state_d = S_WR_P3;
      S_WR_P3:   state_d = S_WR_CTRL;
      S_WR_CTRL: begin
        running_d = 1'b1;
        state_d   = S_RUN;
      end
      S_CLR_IRQ: state_d = S_CLR_WAIT;
      S_CLR_WAIT: begin
        if (CONTINUOUS) begin
          state_d = S_RUN;
        end else begin
          running_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_STOP_WR: begin
        running_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_SNAP_WR:  state_d = S_SNAP_RD0;
      S_SNAP_RD0: state_d = S_SNAP_RD1;
      // slave readdata lags the address by one cycle, so RDn captures address n-1
      S_SNAP_RD1: begin
        snap_value_d[15:0] = avm_readdata;
        state_d            = S_SNAP_RD2;
      end
      S_SNAP_RD2: begin
        snap_value_d[31:16] = avm_readdata;
        state_d             = S_SNAP_RD3;
      end
      S_SNAP_RD3: begin
        snap_value_d[47:32] = avm_readdata;
        state_d             = S_SNAP_RD4;
      end
      S_SNAP_RD4: begin
        snap_value_d[63:48] = avm_readdata;
        snap_valid_d        = 1'b1;
        state_d             = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_CLR_IRQ) begin
      tick_d       = 1'b1;
      tick_count_d = tick_count_q + TICK_W'(1);
    end
  end

  // Bus outputs are decoded from the next state so they register in step with it.
  always_comb begin
    cs_d      = 1'b0;
    write_n_d = 1'b1;
    addr_d    = '0;
    wdata_d   = '0;
    case (state_d)
      S_WR_P0:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd2; wdata_d = period_d[15:0];  end
      S_WR_P1:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd3; wdata_d = period_d[31:16]; end
      S_WR_P2:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd4; wdata_d = period_d[47:32]; end
      S_WR_P3:    begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd5; wdata_d = period_d[63:48]; end
      S_WR_CTRL:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd1; wdata_d = CTRL_WORD;       end
      S_CLR_IRQ:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd0; end
      S_STOP_WR:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd1; wdata_d = 16'h0008;        end
      S_SNAP_WR:  begin cs_d = 1'b1; write_n_d = 1'b0; addr_d = 4'd6; end
      S_SNAP_RD0: begin cs_d = 1'b1; addr_d = 4'd6; end
      S_SNAP_RD1: begin cs_d = 1'b1; addr_d = 4'd7; end
      S_SNAP_RD2: begin cs_d = 1'b1; addr_d = 4'd8; end
      S_SNAP_RD3: begin cs_d = 1'b1; addr_d = 4'd9; end
      default:    cs_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      running_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      snap_valid_q <= 1'b0;
      snap_value_q <= '0;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      running_q    <= running_d;
      tick_q       <= tick_d;
      tick_count_q <= tick_count_d;
      snap_valid_q <= snap_valid_d;
      snap_value_q <= snap_value_d;
      cs_q         <= cs_d;
      write_n_q    <= write_n_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy           = (state_q != S_IDLE) && (state_q != S_RUN);
  assign running        = running_q;
  assign tick           = tick_q;
  assign tick_count     = tick_count_q;
  assign snap_valid     = snap_valid_q;
  assign snap_value     = snap_value_q;
  assign avm_address    = addr_q;
  assign avm_chipselect = cs_q;
  assign avm_write_n    = write_n_q;
  assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_avalon_master.sv
// Bench for timer_avalon_master: behavioural timer slave, bus-write/read/snapshot
// scoreboard queues, table-driven programming vectors and hand sequences for corners.
module tb_timer_avalon_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_start = 1'b0, cmd_stop = 1'b0, cmd_snap = 1'b0;
  logic [63:0] cfg_period = '0;
  logic        busy, running, tick, snap_valid;
  logic [31:0] tick_count;
  logic [63:0] snap_value;
  logic [3:0]  avm_address;
  logic        avm_chipselect, avm_write_n;
  logic [15:0] avm_writedata, avm_readdata;
  logic        irq;
  logic        force_irq = 1'b0;

  // second instance with a 4-bit tick counter, IRQ driven directly by the bench
  logic        reset2 = 1'b1;
  logic        cmd_start2 = 1'b0;
  logic        busy2, running2, tick2, snap_valid2;
  logic [3:0]  tick_count2;
  logic [63:0] snap_value2;
  logic [3:0]  avm_address2;
  logic        avm_chipselect2, avm_write_n2;
  logic [15:0] avm_writedata2;
  logic        irq2 = 1'b0;

  always #5 clk = ~clk;

  timer_avalon_master #(.TICK_W(32), .CONTINUOUS(1'b1)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
    .cfg_period(cfg_period), .busy(busy), .running(running), .tick(tick), .tick_count(tick_count),
    .snap_valid(snap_valid), .snap_value(snap_value), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq(irq)
  );

  timer_avalon_master #(.TICK_W(4), .CONTINUOUS(1'b1)) dut2 (
    .clk(clk), .reset(reset2), .cmd_start(cmd_start2), .cmd_stop(1'b0), .cmd_snap(1'b0),
    .cfg_period(64'h3), .busy(busy2), .running(running2), .tick(tick2), .tick_count(tick_count2),
    .snap_valid(snap_valid2), .snap_value(snap_value2), .avm_address(avm_address2),
    .avm_chipselect(avm_chipselect2), .avm_write_n(avm_write_n2), .avm_writedata(avm_writedata2),
    .avm_readdata(16'h0000), .irq(irq2)
  );

  // ---------------- timer slave model ----------------
  logic [63:0] t_period = '0, t_cnt = '0, t_snap = '0;
  logic        t_run = 1'b0, t_cont = 1'b0, t_ito = 1'b0, t_to = 1'b0, t_irq = 1'b0;
  logic [15:0] t_rd = '0;

  function automatic logic [63:0] put_hw(input logic [63:0] p, input logic [3:0] a, input logic [15:0] d);
    logic [63:0] r;
    r = p;
    r[(int'(a) - 2) * 16 +: 16] = d;
    return r;
  endfunction

  always @(posedge clk) begin
    t_irq <= t_to & t_ito;
    if (t_run) begin
      if (t_cnt == 64'd0) begin
        t_to  <= 1'b1;
        t_cnt <= t_period;
        if (!t_cont) t_run <= 1'b0;
      end else begin
        t_cnt <= t_cnt - 64'd1;
      end
    end
    if (avm_chipselect && !avm_write_n) begin
      case (avm_address)
        4'd0: t_to <= 1'b0;
        4'd1: begin
          t_ito  <= avm_writedata[0];
          t_cont <= avm_writedata[1];
          if (avm_writedata[2]) t_run <= 1'b1;
          if (avm_writedata[3]) t_run <= 1'b0;
        end
        4'd2, 4'd3, 4'd4, 4'd5: begin
          t_period <= put_hw(t_period, avm_address, avm_writedata);
          t_cnt    <= put_hw(t_period, avm_address, avm_writedata);
          t_run    <= 1'b0;
        end
        4'd6: t_snap <= t_cnt;
        default: ;
      endcase
    end
    if (avm_chipselect && avm_write_n) begin
      case (avm_address)
        4'd6: t_rd <= t_snap[15:0];
        4'd7: t_rd <= t_snap[31:16];
        4'd8: t_rd <= t_snap[47:32];
        4'd9: t_rd <= t_snap[63:48];
        default: t_rd <= 16'h0000;
      endcase
    end
  end

  assign avm_readdata = t_rd;
  assign irq          = t_irq | force_irq;

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [63:0] exp_snap[$];

  int cyc = 0, clr_count = 0, snap_pulses = 0, last_clr = 0;
  bit chk_period = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_wr(input logic [3:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  // bus monitor / scoreboard consumer
  always @(negedge clk) begin
    wr_t e;
    logic clr_now;
    clr_now = avm_chipselect && !avm_write_n && (avm_address == 4'd0);
    if (avm_chipselect && !avm_write_n) begin
      if (avm_address == 4'd0) begin
        clr_count++;
        chk("clr_data", 64'(avm_writedata), 64'h0);
        if (chk_period && last_clr > 0) chk("irq_interval", 64'(cyc - last_clr), 64'd10);
        last_clr = cyc;
      end else if (exp_wr.size() == 0) begin
        chk("unexpected_write", {44'h0, avm_address, avm_writedata}, 64'h0);
      end else begin
        e = exp_wr.pop_front();
        chk("wr_addr", 64'(avm_address), 64'(e.a));
        chk("wr_data", 64'(avm_writedata), 64'(e.d));
        if (avm_address == 4'd6) exp_snap.push_back(t_cnt);
      end
    end
    if (avm_chipselect && avm_write_n) begin
      if (exp_rd.size() == 0) chk("unexpected_read", 64'(avm_address), 64'hF);
      else chk("rd_addr", 64'(avm_address), 64'(exp_rd.pop_front()));
    end
    if (tick || clr_now) chk("tick_vs_clr", 64'(tick), 64'(clr_now));
    if (snap_valid) begin
      snap_pulses++;
      if (exp_snap.size() == 0) chk("unexpected_snap_valid", 64'h1, 64'h0);
      else chk("snap_value", snap_value, exp_snap.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_prog(input logic [63:0] p);
    cfg_period = p;
    cmd_start  = 1'b1;
    push_wr(4'd2, p[15:0]);
    push_wr(4'd3, p[31:16]);
    push_wr(4'd4, p[47:32]);
    push_wr(4'd5, p[63:48]);
    push_wr(4'd1, 16'h0007);
    step();
    cmd_start = 1'b0;
  endtask

  typedef struct {
    logic [63:0] period;
    logic [15:0] hw[4];
    logic [15:0] ctrl;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, c0, tc0, sp0;

    vecs[0].period = 64'h0123_4567_89AB_CDEF;
    vecs[0].hw[0] = 16'hCDEF; vecs[0].hw[1] = 16'h89AB; vecs[0].hw[2] = 16'h4567; vecs[0].hw[3] = 16'h0123;
    vecs[0].ctrl = 16'h0007;
    vecs[1].period = 64'hFFFF_0000_FFFF_0001;
    vecs[1].hw[0] = 16'h0001; vecs[1].hw[1] = 16'hFFFF; vecs[1].hw[2] = 16'h0000; vecs[1].hw[3] = 16'hFFFF;
    vecs[1].ctrl = 16'h0007;
    vecs[2].period = 64'h0000_0000_0000_0009;
    vecs[2].hw[0] = 16'h0009; vecs[2].hw[1] = 16'h0000; vecs[2].hw[2] = 16'h0000; vecs[2].hw[3] = 16'h0000;
    vecs[2].ctrl = 16'h0007;

    // reset state
    step(); step(); step();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_running", 64'(running), 64'h0);
    chk("rst_tick", 64'(tick), 64'h0);
    chk("rst_tick_count", 64'(tick_count), 64'h0);
    chk("rst_snap_valid", 64'(snap_valid), 64'h0);
    chk("rst_snap_value", snap_value, 64'h0);
    chk("rst_cs", 64'(avm_chipselect), 64'h0);
    chk("rst_write_n", 64'(avm_write_n), 64'h1);
    chk("rst_addr", 64'(avm_address), 64'h0);
    chk("rst_wdata", 64'(avm_writedata), 64'h0);
    reset  = 1'b0;
    reset2 = 1'b0;
    step();

    // programming vectors: 5 consecutive writes, running after the control write
    for (int unsigned i = 0; i < 3; i++) begin
      cfg_period = vecs[i].period;
      cmd_start  = 1'b1;
      for (int unsigned j = 0; j < 4; j++) push_wr(4'(j + 2), vecs[i].hw[j]);
      push_wr(4'd1, vecs[i].ctrl);
      step();
      cmd_start = 1'b0;
      chk("prog_busy", 64'(busy), 64'h1);
      chk("prog_tick_count_clr", 64'(tick_count), 64'h0);
      for (int j = 0; j < 5; j++) step();
      chk("prog_writes_done", 64'(exp_wr.size()), 64'h0);
      chk("prog_running", 64'(running), 64'h1);
      chk("prog_idle_after", 64'(busy), 64'h0);
    end

    // continuous operation with period 9: service every 10 clocks
    chk_period = 1'b1;
    last_clr   = 0;
    c0         = clr_count;
    for (k = 0; k < 100 && (clr_count - c0) < 3; k++) step();
    chk("irq3_in_time", 64'(k < 100), 64'h1);
    chk("tick_count_3", 64'(tick_count), 64'd3);
    chk_period = 1'b0;

    // snapshot while running, launched in the gap just after a service
    c0 = clr_count;
    for (k = 0; k < 30 && clr_count == c0; k++) step();
    step(); step();
    chk("snap_launch_idle", 64'(busy), 64'h0);
    sp0      = snap_pulses;
    cmd_snap = 1'b1;
    push_wr(4'd6, 16'h0000);
    for (int j = 6; j <= 9; j++) exp_rd.push_back(4'(j));
    step();
    cmd_snap = 1'b0;
    for (k = 0; k < 20 && snap_pulses == sp0; k++) step();
    step(); step(); step();
    chk("snap_pulse_once", 64'(snap_pulses - sp0), 64'h1);

    // irq arriving mid-snapshot is serviced right after it
    start_prog(64'h0000_0000_0010_0000);
    for (int j = 0; j < 20; j++) step();
    tc0      = int'(tick_count);
    sp0      = snap_pulses;
    cmd_snap = 1'b1;
    push_wr(4'd6, 16'h0000);
    for (int j = 6; j <= 9; j++) exp_rd.push_back(4'(j));
    step();
    cmd_snap = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      chk("snap_rd_cycle", {avm_chipselect, avm_write_n, avm_address}, {2'b11, 4'(j + 6)});
      if (j == 2) force_irq = 1'b1;
    end
    for (k = 0; k < 10 && snap_pulses == sp0; k++) step();
    c0 = clr_count;
    for (k = 0; k < 2 && clr_count == c0; k++) step();
    chk("clr_after_snap", 64'(clr_count - c0), 64'h1);
    force_irq = 1'b0;
    step(); step(); step();
    chk("tick_count_plus1", 64'(tick_count), 64'(tc0 + 1));

    // reset during WR_P2 abandons the sequence
    cfg_period = 64'h5;
    cmd_start  = 1'b1;
    push_wr(4'd2, 16'h0005);
    push_wr(4'd3, 16'h0000);
    push_wr(4'd4, 16'h0000);
    step();
    cmd_start = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst_cs", 64'(avm_chipselect), 64'h0);
    chk("midrst_running", 64'(running), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_write_n", 64'(avm_write_n), 64'h1);
    chk("midrst_queue", 64'(exp_wr.size()), 64'h0);
    reset = 1'b0;
    step();

    // stop, then irq and snap in IDLE are ignored
    start_prog(64'h0000_0000_0010_0000);
    for (int j = 0; j < 8; j++) step();
    chk("stop_pre_running", 64'(running), 64'h1);
    cmd_stop = 1'b1;
    push_wr(4'd1, 16'h0008);
    step();
    cmd_stop = 1'b0;
    step();
    chk("stop_running", 64'(running), 64'h0);
    chk("stop_queue", 64'(exp_wr.size()), 64'h0);
    tc0       = int'(tick_count);
    c0        = clr_count;
    force_irq = 1'b1;
    for (int j = 0; j < 20; j++) step();
    force_irq = 1'b0;
    chk("idle_irq_no_clr", 64'(clr_count - c0), 64'h0);
    chk("idle_irq_no_tick", 64'(tick_count), 64'(tc0));
    cmd_snap = 1'b1;
    step();
    cmd_snap = 1'b0;
    k = 0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (avm_chipselect) k++;
    end
    chk("idle_snap_no_bus", 64'(k), 64'h0);

    // 4-bit tick counter wraps 15 -> 0
    cmd_start2 = 1'b1;
    step();
    cmd_start2 = 1'b0;
    for (int j = 0; j < 6; j++) step();
    chk("dut2_running", 64'(running2), 64'h1);
    for (int i = 0; i < 16; i++) begin
      irq2 = 1'b1;
      for (k = 0; k < 10 && !(avm_chipselect2 && !avm_write_n2 && avm_address2 == 4'd0); k++) step();
      irq2 = 1'b0;
      step(); step(); step();
      chk("dut2_tick_count", 64'(tick_count2), 64'((i + 1) % 16));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
